// File: rtl/link_tx_scheduler.sv
// Transmit scheduler for one DS link port: arbitrates two N-char requesters packet by packet,
// interleaves FCT L-chars and enforces credit-based flow control on the shared encoder.
module link_tx_scheduler #(
    parameter int CREDIT_PER_FCT = 8,
    parameter int MAX_CREDIT     = 56,
    parameter int CW             = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          link_up,
    input  logic          fct_rx,
    input  logic          fct_req,
    input  logic          req0_valid,
    input  logic [8:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [8:0]    req1_data,
    output logic          req1_ready,
    output logic          enc_valid,
    output logic [1:0]    enc_char,
    output logic [7:0]    enc_data,
    input  logic          enc_ready,
    output logic [CW-1:0] credit,
    output logic          credit_err
);

    typedef enum logic [1:0] {IDLE, PKT0, PKT1} state_t;

    localparam logic [1:0] CHAR_DATA = 2'b00;
    localparam logic [1:0] CHAR_FCT  = 2'b01;
    localparam logic [1:0] CHAR_EOP  = 2'b10;

    state_t      state, stateNext;
    logic        lastGrant, lastGrantNext;
    logic [2:0]  fctPend;
    logic        loadEn, fctSel, nSel;
    logic        pick, pickValid;
    logic [8:0]  selData;
    logic [CW:0] creditSum;
    logic        creditOvf;

    // Pick the candidate requester: round-robin on ties in IDLE, packet owner otherwise
    always_comb begin
        pick      = 1'b0;
        pickValid = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    pick      = ~lastGrant;
                    pickValid = 1'b1;
                end else if (req0_valid) begin
                    pick      = 1'b0;
                    pickValid = 1'b1;
                end else if (req1_valid) begin
                    pick      = 1'b1;
                    pickValid = 1'b1;
                end
            end
            PKT0: begin
                pick      = 1'b0;
                pickValid = req0_valid;
            end
            PKT1: begin
                pick      = 1'b1;
                pickValid = req1_valid;
            end
            default: begin
                pick      = 1'b0;
                pickValid = 1'b0;
            end
        endcase
    end

    // FCTs preempt N-chars even mid-packet; N-chars need credit
    always_comb begin
        selData    = pick ? req1_data : req0_data;
        loadEn     = link_up & (~enc_valid | enc_ready);
        fctSel     = loadEn & (fctPend != 3'd0);
        nSel       = loadEn & ~fctSel & (credit != '0) & pickValid;
        req0_ready = nSel & ~pick;
        req1_ready = nSel & pick;
    end

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        if (nSel) begin
            if (selData[8]) begin
                stateNext     = IDLE;
                lastGrantNext = pick;
            end else begin
                stateNext = pick ? PKT1 : PKT0;
            end
        end
    end

    // One extra bit so credit plus a full FCT increment cannot wrap before the ceiling test
    always_comb begin
        creditSum = {1'b0, credit};
        if (fct_rx) begin
            creditSum = creditSum + (CW+1)'(CREDIT_PER_FCT);
        end
        if (nSel) begin
            creditSum = creditSum - (CW+1)'(1);
        end
        creditOvf = creditSum > (CW+1)'(MAX_CREDIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lastGrant  <= 1'b1;
            fctPend    <= 3'd0;
            credit     <= '0;
            credit_err <= 1'b0;
            enc_valid  <= 1'b0;
            enc_char   <= CHAR_DATA;
            enc_data   <= 8'd0;
        end else if (!link_up) begin
            state      <= IDLE;
            fctPend    <= 3'd0;
            credit     <= '0;
            credit_err <= 1'b0;
            enc_valid  <= 1'b0;
            enc_char   <= CHAR_DATA;
            enc_data   <= 8'd0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            if (creditOvf) begin
                credit     <= CW'(MAX_CREDIT);
                credit_err <= 1'b1;
            end else begin
                credit <= creditSum[CW-1:0];
            end
            case ({fct_req, fctSel})
                2'b10:   if (fctPend != 3'd7) fctPend <= fctPend + 3'd1;
                2'b01:   fctPend <= fctPend - 3'd1;
                default: fctPend <= fctPend;
            endcase
            if (fctSel) begin
                enc_valid <= 1'b1;
                enc_char  <= CHAR_FCT;
                enc_data  <= 8'd0;
            end else if (nSel) begin
                enc_valid <= 1'b1;
                enc_char  <= selData[8] ? CHAR_EOP : CHAR_DATA;
                enc_data  <= selData[8] ? 8'd0 : selData[7:0];
            end else if (loadEn) begin
                enc_valid <= 1'b0;
                enc_char  <= CHAR_DATA;
                enc_data  <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed, table-driven bench for link_tx_scheduler: each record gives one cycle of inputs
// and the outputs expected during that cycle (registered state plus combinational readies).
module tb_link_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_up, fct_rx, fct_req;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [8:0] req0_data, req1_data;
    logic       enc_valid, enc_ready;
    logic [1:0] enc_char;
    logic [7:0] enc_data;
    logic [5:0] credit;
    logic       credit_err;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    localparam logic [1:0] D = 2'b00;
    localparam logic [1:0] F = 2'b01;
    localparam logic [1:0] E = 2'b10;
    localparam logic [8:0] EOP = 9'h100;

    typedef struct {
        logic       lu, frx, freq, v0;
        logic [8:0] d0;
        logic       v1;
        logic [8:0] d1;
        logic       er;
        logic       r0, r1, ev;
        logic [1:0] ec;
        logic [7:0] ed;
        logic [5:0] cr;
        logic       ce;
    } vec_t;

    vec_t vecs[$];

    link_tx_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .link_up    (link_up),
        .fct_rx     (fct_rx),
        .fct_req    (fct_req),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .enc_valid  (enc_valid),
        .enc_char   (enc_char),
        .enc_data   (enc_data),
        .enc_ready  (enc_ready),
        .credit     (credit),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic lu, input logic frx, input logic freq,
                                input logic v0, input logic [8:0] d0,
                                input logic v1, input logic [8:0] d1, input logic er,
                                input logic r0, input logic r1, input logic ev,
                                input logic [1:0] ec, input logic [7:0] ed,
                                input logic [5:0] cr, input logic ce);
        vec_t v;
        v.lu = lu;  v.frx = frx; v.freq = freq;
        v.v0 = v0;  v.d0 = d0;   v.v1 = v1; v.d1 = d1; v.er = er;
        v.r0 = r0;  v.r1 = r1;   v.ev = ev; v.ec = ec; v.ed = ed;
        v.cr = cr;  v.ce = ce;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        link_up    = v.lu;
        fct_rx     = v.frx;
        fct_req    = v.freq;
        req0_valid = v.v0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_data  = v.d1;
        enc_ready  = v.er;
    endtask

    task automatic checkOutput(input vec_t v);
        #1;
        cmp("req0_ready", 8'(req0_ready), 8'(v.r0));
        cmp("req1_ready", 8'(req1_ready), 8'(v.r1));
        cmp("enc_valid",  8'(enc_valid),  8'(v.ev));
        cmp("enc_char",   8'(enc_char),   8'(v.ec));
        cmp("enc_data",   enc_data,       v.ed);
        cmp("credit",     8'(credit),     8'(v.cr));
        cmp("credit_err", 8'(credit_err), 8'(v.ce));
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
        step++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        link_up = 0; fct_rx = 0; fct_req = 0; enc_ready = 0;
        req0_valid = 0; req0_data = 0; req1_valid = 0; req1_data = 0;

        // Reset state
        runVec(mk(0,0,0, 0,0, 0,0, 0,  0,0,0,D,0,0,0));
        rst = 1'b0;
        runVec(mk(0,0,0, 0,0, 0,0, 0,  0,0,0,D,0,0,0));

        // No credit: request stalls; then one FCT and an 8-char packet drains it
        vecs.push_back(mk(1,0,0, 1,9'h05A, 0,0, 1,  0,0,0,D,0,0,0));
        vecs.push_back(mk(1,0,0, 1,9'h05A, 0,0, 1,  0,0,0,D,0,0,0));
        vecs.push_back(mk(1,1,0, 0,0,      0,0, 1,  0,0,0,D,0,0,0));
        vecs.push_back(mk(1,0,0, 1,9'h001, 0,0, 1,  1,0,0,D,0,8,0));
        for (int k = 2; k <= 7; k++)
            vecs.push_back(mk(1,0,0, 1,9'(k), 0,0, 1,  1,0,1,D,8'(k-1),6'(9-k),0));
        vecs.push_back(mk(1,0,0, 1,EOP,    0,0, 1,  1,0,1,D,8'h07,1,0));
        vecs.push_back(mk(1,0,0, 1,9'h0AA, 0,0, 1,  0,0,1,E,0,0,0));
        vecs.push_back(mk(1,0,0, 1,9'h0AA, 0,0, 1,  0,0,0,D,0,0,0));
        // Two FCTs, then a tie: last grant was requester 0, so requester 1 wins
        vecs.push_back(mk(1,1,0, 0,0, 0,0, 1,  0,0,0,D,0,0,0));
        vecs.push_back(mk(1,1,0, 0,0, 0,0, 1,  0,0,0,D,0,8,0));
        vecs.push_back(mk(1,0,0, 1,9'h011, 1,9'h021, 1,  0,1,0,D,0,16,0));
        vecs.push_back(mk(1,0,0, 1,9'h011, 1,9'h022, 1,  0,1,1,D,8'h21,15,0));
        vecs.push_back(mk(1,0,0, 1,9'h011, 1,9'h023, 1,  0,1,1,D,8'h22,14,0));
        vecs.push_back(mk(1,0,0, 1,9'h011, 1,EOP,    1,  0,1,1,D,8'h23,13,0));
        vecs.push_back(mk(1,0,0, 1,9'h011, 1,9'h031, 1,  1,0,1,E,0,12,0));
        vecs.push_back(mk(1,0,0, 1,9'h012, 1,9'h031, 1,  1,0,1,D,8'h11,11,0));
        vecs.push_back(mk(1,0,0, 1,9'h013, 1,9'h031, 1,  1,0,1,D,8'h12,10,0));
        vecs.push_back(mk(1,0,0, 1,EOP,    1,9'h031, 1,  1,0,1,D,8'h13,9,0));
        // Requester 1 packet with an FCT request slipped in mid-packet
        vecs.push_back(mk(1,0,0, 0,0, 1,9'h031, 1,  0,1,1,E,0,8,0));
        vecs.push_back(mk(1,0,1, 0,0, 1,9'h032, 1,  0,1,1,D,8'h31,7,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,9'h033, 1,  0,0,1,D,8'h32,6,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,9'h033, 1,  0,1,1,F,0,6,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,EOP,    1,  0,1,1,D,8'h33,5,0));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,      1,  0,0,1,E,0,4,0));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,      1,  0,0,0,D,0,4,0));

        foreach (vecs[i]) runVec(vecs[i]);

        // Encoder backpressure: output holds, no readies; then FCT receipt with a load nets +7
        runVec(mk(1,0,0, 1,9'h041, 0,0, 1,  1,0,0,D,0,4,0));
        for (int s = 0; s < 4; s++)
            runVec(mk(1,0,0, 1,9'h042, 0,0, 0,  0,0,1,D,8'h41,3,0));
        runVec(mk(1,1,0, 1,9'h042, 0,0, 1,  1,0,1,D,8'h41,3,0));
        runVec(mk(1,0,0, 1,EOP,    0,0, 1,  1,0,1,D,8'h42,10,0));

        // Eight FCTs push credit past the ceiling
        for (int i = 0; i < 8; i++) begin
            int sum;
            sum = 9 + 8 * i;
            runVec(mk(1,1,0, 0,0, 0,0, 1,  0,0,(i == 0),(i == 0) ? E : D,0,
                      (sum > 56) ? 6'd56 : 6'(sum),(sum > 56)));
        end

        // Drop link mid-packet: everything flushes, FCT inputs ignored while down
        runVec(mk(1,0,0, 0,0, 1,9'h051, 1,  0,1,0,D,0,56,1));
        runVec(mk(0,0,0, 0,0, 1,9'h052, 1,  0,0,1,D,8'h51,55,1));
        runVec(mk(0,1,1, 0,0, 0,0,      1,  0,0,0,D,0,0,0));
        runVec(mk(1,0,0, 0,0, 0,0,      1,  0,0,0,D,0,0,0));
        runVec(mk(1,0,0, 0,0, 0,0,      1,  0,0,0,D,0,0,0));

        // Last grant survives link drop: tie goes to requester 1
        runVec(mk(1,1,0, 0,0,      0,0,      1,  0,0,0,D,0,0,0));
        runVec(mk(1,0,0, 1,9'h061, 1,9'h071, 1,  0,1,0,D,0,8,0));
        runVec(mk(1,0,0, 0,0,      0,0,      1,  0,0,1,D,8'h71,7,0));

        // After reset the first tie goes to requester 0
        rst = 1'b1;
        runVec(mk(0,0,0, 0,0, 0,0, 0,  0,0,0,D,0,0,0));
        rst = 1'b0;
        runVec(mk(1,1,0, 0,0,      0,0,      1,  0,0,0,D,0,0,0));
        runVec(mk(1,0,0, 1,9'h061, 1,9'h071, 1,  1,0,0,D,0,8,0));
        runVec(mk(1,0,0, 0,0,      0,0,      1,  0,0,1,D,8'h61,7,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
